// File: rtl/lcd_spi_rx_pkg.sv
// Shared types and constants for the LCD SPI receiver.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package lcd_spi_rx_pkg;

    // Receiver FSM: IDLE holds no bits, SHIFT holds 1..7 bits of a byte.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } rx_state_t;

    localparam int BYTE_W = 8;

    // One FIFO entry: the A0 flag travels with its byte.
    typedef struct packed {
        logic              is_data;
        logic [BYTE_W-1:0] data;
    } rx_entry_t;

    localparam int ENTRY_W = $bits(rx_entry_t);

endpackage

// File: rtl/lcd_spi_rx_sync_fifo.sv
// Single-clock first-word-fall-through FIFO, DEPTH a power of two (2..16).
// Latency: a pushed word is visible on o_dat/o_vld the cycle after the push.
// Backpressure: push while full is dropped unless a pop happens the same cycle.
// Ports: i_clk/i_rst (async active-high), i_push/i_push_dat write side,
//        i_pop read side (ignored while empty), o_dat/o_vld head, o_full.
module sync_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dat,
    output logic             o_vld,
    output logic             o_full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_empty;
    logic w_pop;
    logic w_wr;

    assign w_empty = (r_count == '0);
    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign w_pop   = i_pop & ~w_empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign w_wr    = i_push & (~o_full | w_pop);

    assign o_vld = ~w_empty;
    // Head reads as zero while empty so the outputs are clean after reset.
    assign o_dat = w_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_push_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/lcd_spi_rx.sv
// LCD SPI slave receiver: samples SDA on SCK rise, queues {A0, byte} in a FIFO.
// Latency: rx_valid rises 4 CLK cycles after the 8th SCK rising edge (empty FIFO).
// Backpressure: rx_valid/rx_ready pop; a byte arriving to a full FIFO is dropped, overflow sticks.
// Ports: CLK, RESET (async active-high); SCK/SDA/A0/LCD_RST_N asynchronous serial inputs;
//        rx_data/rx_is_data/rx_valid/rx_ready consumer side; overflow (sticky), frame_error (pulse).
module lcd_spi_rx
    import lcd_spi_rx_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              SCK,
    input  logic              SDA,
    input  logic              A0,
    input  logic              LCD_RST_N,
    output logic [BYTE_W-1:0] rx_data,
    output logic              rx_is_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              overflow,
    output logic              frame_error
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT_CYCLES);

    // Synchronizer bit positions: {LCD_RST_N, A0, SDA, SCK}
    localparam int I_SCK = 0;
    localparam int I_SDA = 1;
    localparam int I_A0  = 2;
    localparam int I_RST = 3;

    logic [3:0]        r_sync1;
    logic [3:0]        r_sync2;
    logic              r_sck_d;

    logic              w_sck;
    logic              w_sda;
    logic              w_a0;
    logic              w_lcd_rst_n;
    logic              w_sck_rise;
    logic              w_sck_edge;

    rx_state_t         r_state;
    logic [BYTE_W-2:0] r_shift;
    logic [2:0]        r_bit_cnt;
    logic [CW-1:0]     r_idle_cnt;
    logic              r_push_vld;
    rx_entry_t         r_push_dat;
    logic              r_frame_error;
    logic              r_overflow;

    logic [ENTRY_W-1:0] w_fifo_dat;
    rx_entry_t          w_head;
    logic               w_fifo_vld;
    logic               w_fifo_full;
    logic               w_pop;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_sck_d <= 1'b0;
        end else begin
            r_sync1 <= {LCD_RST_N, A0, SDA, SCK};
            r_sync2 <= r_sync1;
            r_sck_d <= r_sync2[I_SCK];
        end
    end

    assign w_sck       = r_sync2[I_SCK];
    assign w_sda       = r_sync2[I_SDA];
    assign w_a0        = r_sync2[I_A0];
    assign w_lcd_rst_n = r_sync2[I_RST];
    assign w_sck_rise  = w_sck & ~r_sck_d;
    assign w_sck_edge  = w_sck ^ r_sck_d;

    // Inactivity counter: any SCK transition restarts it, it parks at the limit.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_idle_cnt <= '0;
        end else if (!w_lcd_rst_n || w_sck_edge) begin
            r_idle_cnt <= '0;
        end else if (r_idle_cnt != TO_VAL) begin
            r_idle_cnt <= r_idle_cnt + CW'(1);
        end
    end

    // Only bits 6..0 need storing; the 8th bit goes straight into the push word.
    // The push is registered, which sets the 4-cycle pin-to-rx_valid latency.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state       <= IDLE;
            r_shift       <= '0;
            r_bit_cnt     <= '0;
            r_push_vld    <= 1'b0;
            r_push_dat    <= '0;
            r_frame_error <= 1'b0;
        end else begin
            r_push_vld    <= 1'b0;
            r_frame_error <= 1'b0;
            if (!w_lcd_rst_n) begin
                r_state   <= IDLE;
                r_shift   <= '0;
                r_bit_cnt <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_sck_rise) begin
                            r_shift   <= {{(BYTE_W-2){1'b0}}, w_sda};
                            r_bit_cnt <= 3'd1;
                            r_state   <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        if (w_sck_rise) begin
                            if (r_bit_cnt == 3'd7) begin
                                r_push_vld         <= 1'b1;
                                r_push_dat.is_data <= w_a0;
                                r_push_dat.data    <= {r_shift, w_sda};
                                r_shift            <= '0;
                                r_bit_cnt          <= '0;
                                r_state            <= IDLE;
                            end else begin
                                r_shift   <= {r_shift[BYTE_W-3:0], w_sda};
                                r_bit_cnt <= r_bit_cnt + 3'd1;
                            end
                        end else if (r_idle_cnt == TO_VAL) begin
                            r_frame_error <= 1'b1;
                            r_shift       <= '0;
                            r_bit_cnt     <= '0;
                            r_state       <= IDLE;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign w_pop = w_fifo_vld & rx_ready;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_overflow <= 1'b0;
        end else if (r_push_vld && w_fifo_full && !w_pop) begin
            r_overflow <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk      (CLK),
        .i_rst      (RESET),
        .i_push     (r_push_vld),
        .i_push_dat (r_push_dat),
        .i_pop      (w_pop),
        .o_dat      (w_fifo_dat),
        .o_vld      (w_fifo_vld),
        .o_full     (w_fifo_full)
    );

    assign w_head      = w_fifo_dat;
    assign rx_data     = w_head.data;
    assign rx_is_data  = w_head.is_data;
    assign rx_valid    = w_fifo_vld;
    assign overflow    = r_overflow;
    assign frame_error = r_frame_error;

endmodule

// File: tb/tb_lcd_spi_rx.sv
// Directed bench for lcd_spi_rx: table of bytes plus corner-case sequences.
// Inputs change 1 time unit after each rising CLK edge; outputs are read there too.
// Pops and frame_error pulses are recorded on the falling CLK edge.
module tb_lcd_spi_rx;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       SCK = 1'b0;
    logic       SDA = 1'b0;
    logic       A0 = 1'b0;
    logic       LCD_RST_N = 1'b1;
    logic [7:0] rx_data;
    logic       rx_is_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       overflow;
    logic       frame_error;

    int n_chk = 0;
    int n_err = 0;
    int fe_cnt = 0;
    logic [8:0] popq[$];

    lcd_spi_rx #(
        .TIMEOUT_CYCLES (255),
        .FIFO_DEPTH     (4)
    ) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .SCK         (SCK),
        .SDA         (SDA),
        .A0          (A0),
        .LCD_RST_N   (LCD_RST_N),
        .rx_data     (rx_data),
        .rx_is_data  (rx_is_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .overflow    (overflow),
        .frame_error (frame_error)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (rx_valid && rx_ready) popq.push_back({rx_is_data, rx_data});
        if (frame_error) fe_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] d;
        logic       a0;
        logic [7:0] exp_d;
        logic       exp_isd;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic bit_rise(input logic b);
        SDA = b;
        tick(3);
        SCK = 1'b1;
    endtask

    task automatic bit_fall();
        tick(4);
        SCK = 1'b0;
    endtask

    task automatic send_bits(input logic [7:0] d, input int nbits);
        for (int b = 7; b > 7 - nbits; b--) begin
            bit_rise(d[b]);
            bit_fall();
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input logic a0);
        A0 = a0;
        send_bits(d, 8);
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        tick(2);
        RESET = 1'b0;
        tick(4);
    endtask

    task automatic pop_one();
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
    endtask

    initial begin
        int fe_base;
        int q_base;
        logic [8:0] ent;
        logic [7:0] d;

        vecs[0] = '{d: 8'hAF, a0: 1'b0, exp_d: 8'hAF, exp_isd: 1'b0};
        vecs[1] = '{d: 8'h55, a0: 1'b1, exp_d: 8'h55, exp_isd: 1'b1};
        vecs[2] = '{d: 8'h00, a0: 1'b1, exp_d: 8'h00, exp_isd: 1'b1};
        vecs[3] = '{d: 8'hFF, a0: 1'b0, exp_d: 8'hFF, exp_isd: 1'b0};
        vecs[4] = '{d: 8'h81, a0: 1'b1, exp_d: 8'h81, exp_isd: 1'b1};

        // Reset state, sampled while RESET is held.
        tick(2);
        chk("rst_rx_valid", 16'(rx_valid), 16'h0);
        chk("rst_rx_data", 16'(rx_data), 16'h0);
        chk("rst_rx_is_data", 16'(rx_is_data), 16'h0);
        chk("rst_overflow", 16'(overflow), 16'h0);
        chk("rst_frame_error", 16'(frame_error), 16'h0);
        RESET = 1'b0;
        tick(4);

        // rx_ready while empty does nothing.
        rx_ready = 1'b1;
        tick(3);
        chk("empty_ready_valid", 16'(rx_valid), 16'h0);

        // Table-driven bytes, consumer always ready; latency checked on the first.
        fe_base = fe_cnt;
        q_base = popq.size();
        for (int i = 0; i < 5; i++) begin
            d = vecs[i].d;
            A0 = vecs[i].a0;
            send_bits(d, 7);
            bit_rise(d[0]);
            if (i == 0) begin
                tick(3);
                chk("latency_3cyc_valid", 16'(rx_valid), 16'h0);
                tick(1);
                chk("latency_4cyc_valid", 16'(rx_valid), 16'h1);
                chk("latency_4cyc_data", 16'(rx_data), 16'hAF);
                SCK = 1'b0;
            end else begin
                bit_fall();
            end
        end
        tick(10);
        chk("table_pop_count", 16'(popq.size() - q_base), 16'd5);
        for (int i = 0; i < 5; i++) begin
            ent = (q_base + i < popq.size()) ? popq[q_base + i] : 9'h1FF;
            chk($sformatf("table%0d_data", i), 16'(ent[7:0]), 16'(vecs[i].exp_d));
            chk($sformatf("table%0d_is_data", i), 16'(ent[8]), 16'(vecs[i].exp_isd));
        end
        chk("table_no_frame_error", 16'(fe_cnt - fe_base), 16'h0);
        rx_ready = 1'b0;

        // Partial byte then SCK idle past the timeout, then a clean byte.
        do_reset();
        fe_base = fe_cnt;
        A0 = 1'b1;
        send_bits(8'hA0, 3);
        tick(275);
        chk("timeout_fe_pulses", 16'(fe_cnt - fe_base), 16'h1);
        chk("timeout_no_push", 16'(rx_valid), 16'h0);
        send_byte(8'h3C, 1'b1);
        tick(10);
        chk("timeout_next_valid", 16'(rx_valid), 16'h1);
        chk("timeout_next_data", 16'(rx_data), 16'h3C);
        chk("timeout_next_is_data", 16'(rx_is_data), 16'h1);
        pop_one();
        chk("timeout_single_entry", 16'(rx_valid), 16'h0);
        chk("timeout_fe_total", 16'(fe_cnt - fe_base), 16'h1);

        // Five bytes into a depth-4 FIFO with no consumer.
        do_reset();
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b0);
        tick(10);
        chk("ovf_set", 16'(overflow), 16'h1);
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("ovf_entry%0d_valid", i), 16'(rx_valid), 16'h1);
            chk($sformatf("ovf_entry%0d_data", i), 16'(rx_data), 16'(i));
            pop_one();
        end
        chk("ovf_drained", 16'(rx_valid), 16'h0);
        tick(5);
        chk("ovf_sticky", 16'(overflow), 16'h1);

        // Full FIFO: pop lands on the same cycle as the 8th-bit push of 0x99.
        do_reset();
        for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b0);
        tick(5);
        chk("full_pre_overflow", 16'(overflow), 16'h0);
        A0 = 1'b1;
        send_bits(8'h99, 7);
        bit_rise(1'b1);
        tick(3);
        rx_ready = 1'b1;
        tick(1);
        rx_ready = 1'b0;
        SCK = 1'b0;
        tick(5);
        chk("full_pushpop_overflow", 16'(overflow), 16'h0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("full_entry%0d_data", i), 16'(rx_data), (i < 3) ? 16'(i + 2) : 16'h99);
            pop_one();
        end
        chk("full_drained", 16'(rx_valid), 16'h0);

        // LCD reset mid-byte discards the partial byte silently.
        do_reset();
        fe_base = fe_cnt;
        A0 = 1'b0;
        send_bits(8'hF0, 4);
        LCD_RST_N = 1'b0;
        tick(6);
        LCD_RST_N = 1'b1;
        tick(6);
        send_byte(8'hC8, 1'b0);
        tick(10);
        chk("lcdrst_valid", 16'(rx_valid), 16'h1);
        chk("lcdrst_data", 16'(rx_data), 16'hC8);
        chk("lcdrst_is_data", 16'(rx_is_data), 16'h0);
        pop_one();
        chk("lcdrst_only_entry", 16'(rx_valid), 16'h0);
        chk("lcdrst_no_fe", 16'(fe_cnt - fe_base), 16'h0);

        // Global reset mid-byte with two entries queued.
        do_reset();
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        tick(5);
        chk("rst_mid_pre_valid", 16'(rx_valid), 16'h1);
        send_bits(8'hE0, 3);
        fe_base = fe_cnt;
        RESET = 1'b1;
        #1;
        chk("rst_mid_valid", 16'(rx_valid), 16'h0);
        chk("rst_mid_data", 16'(rx_data), 16'h0);
        chk("rst_mid_is_data", 16'(rx_is_data), 16'h0);
        chk("rst_mid_overflow", 16'(overflow), 16'h0);
        chk("rst_mid_frame_error", 16'(frame_error), 16'h0);
        tick(2);
        RESET = 1'b0;
        tick(300);
        chk("rst_mid_after_valid", 16'(rx_valid), 16'h0);
        chk("rst_mid_after_fe", 16'(fe_cnt - fe_base), 16'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/lcd_spi_rx.md
LCD_SPI_RX -- requirements
Module: lcd_spi_rx

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, meaning CLK cycles of SCK inactivity that abort a partial byte.
REQ-002 Parameter FIFO_DEPTH, default 4, meaning received-byte FIFO entries; power of two, 2..16.
REQ-003 The clocking and reset scheme SHALL be: one clock; reset is asynchronous and active-high.
REQ-004 CLK  input  1  system clock, the only clock.
REQ-005 RESET  input  1  asynchronous active-high reset.
REQ-006 SCK  input  1  serial clock from the LCD SPI master, asynchronous to CLK.
REQ-007 SDA  input  1  serial data, MSB first, sampled on SCK rising edge.
REQ-008 A0  input  1  0 = command byte, 1 = display data byte.
REQ-009 LCD_RST_N  input  1  LCD reset line, active-low; when low, the receiver is held idle.
REQ-010 rx_data  output  8  head-of-FIFO byte.
REQ-011 rx_is_data  output  1  A0 value captured with rx_data.
REQ-012 rx_valid  output  1  FIFO not empty.
REQ-013 rx_ready  input  1  consumer accepts the head byte when rx_valid and rx_ready are both high.
REQ-014 overflow  output  1  sticky; set when a byte is dropped because the FIFO is full.
REQ-015 frame_error  output  1  one-cycle pulse when a partial byte is aborted.

Function
REQ-016 SCK, SDA, A0 and LCD_RST_N SHALL each pass through a 2-flop synchronizer; SCK rising edge is detected on the synchronized signal.
REQ-017 Valid input: SCK high and low phases each >= 3 CLK cycles; SDA/A0 stable >= 3 CLK cycles around each SCK rising edge.
REQ-018 FSM states: IDLE (bit count 0), SHIFT (1..7 bits held), with transitions defined by REQ-019..REQ-022.
REQ-019 IDLE -> SHIFT on an SCK rising edge; that edge's SDA becomes bit 7.
REQ-020 SHIFT: each SCK rising edge shifts in one bit; on the 8th bit, {A0, byte} is pushed and the FSM returns to IDLE in the same cycle.
REQ-021 SHIFT -> IDLE with frame_error pulse when the idle counter reaches TIMEOUT_CYCLES; the partial byte is discarded.
REQ-022 Synchronized LCD_RST_N low forces IDLE, clears the shift register and idle counter, does not flush the FIFO, and does not pulse frame_error.
REQ-023 The idle counter clears on every SCK edge (either direction) and saturates at TIMEOUT_CYCLES.
REQ-024 Latency: rx_valid SHALL assert exactly 4 CLK cycles after the 8th SCK rising edge at the pin, given an empty FIFO.
REQ-025 FIFO: first-word-fall-through; rx_data/rx_is_data valid whenever rx_valid is high; pointers wrap modulo FIFO_DEPTH.
REQ-026 Push while full and no pop in the same cycle: byte dropped, overflow set; contents unchanged.
REQ-027 Push and pop in the same cycle while full: both succeed and occupancy is unchanged with no overflow.
REQ-028 Push and pop in the same cycle while empty: the pushed byte is presented next cycle.
REQ-029 rx_ready while rx_valid is low SHALL have no effect.
REQ-030 overflow SHALL be cleared only by RESET.

Reset
REQ-031 RESET SHALL asynchronously set: FSM IDLE, shift register 0, bit count 0, idle counter 0, FIFO empty, rx_valid 0, rx_data 0, rx_is_data 0, overflow 0, frame_error 0, synchronizer flops 0.
REQ-032 Reset mid-byte: the partial byte is lost, with no frame_error pulse and no FIFO push after release.
REQ-033 After reset release, the first SCK rising edge SHALL be detected no earlier than 3 CLK cycles after release.

Structure
REQ-034 The shared package SHALL hold the FSM state enum (IDLE, SHIFT), the byte width constant 8, and the FIFO entry type {is_data, data[7:0]}.
REQ-035 The FIFO SHALL be one sub-module, sync_fifo, parameterised by width 9 and FIFO_DEPTH; all other logic lives in lcd_spi_rx.

Verification
REQ-036 Send command 0xAF (A0=0), then data 0x55 (A0=1), with rx_ready=1 -> pops 0xAF/is_data 0, then 0x55/is_data 1; first rx_valid is 4 cycles after the 8th edge.
REQ-037 Send 3 bits, then hold SCK for 255 cycles, then send 0x3C -> one frame_error pulse and a single FIFO entry 0x3C.
REQ-038 Send 5 bytes 0x01..0x05 with rx_ready=0 and FIFO_DEPTH=4 -> FIFO holds 0x01..0x04, overflow=1, 0x05 dropped.
REQ-039 With the FIFO full, pop on the same cycle as the 8th-bit push of 0x99 -> no overflow, 0x99 becomes the last entry.
REQ-040 Drive LCD_RST_N low after 4 bits, then high, then send 0xC8 -> FIFO contains only 0xC8 and there is no frame_error.
REQ-041 Assert RESET mid-byte with the FIFO holding 2 entries -> all outputs 0 and the FIFO is empty.
